// File: rtl/pa_ifu_fetch_arb.sv
// pa_ifu_fetch_arb: fixed-priority IFU fetch arbiter with request lock and abort-aware in-flight tracking.
// Optional: define PA_IFU_ARB_SEQ_THROTTLE_EN to limit sequential (ibuf) prefetch to one in-flight fetch.
module pa_ifu_fetch_arb #(
    parameter int unsigned OUTSTD_MAX = 2
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        vec_arb_req_vld,
    input  logic [31:0] vec_arb_req_addr,
    input  logic        pcgen_arb_req_vld,
    input  logic [31:0] pcgen_arb_req_addr,
    input  logic        ibuf_arb_req_vld,
    input  logic [31:0] ibuf_arb_req_addr,
    input  logic        ctrl_arb_abort,
    output logic        arb_bus_req_vld,
    output logic [31:0] arb_bus_req_addr,
    input  logic        bus_arb_req_grnt,
    input  logic        bus_arb_rsp_vld,
    input  logic [31:0] bus_arb_rsp_data,
    input  logic        bus_arb_rsp_err,
    output logic        arb_vec_grnt,
    output logic        arb_pcgen_grnt,
    output logic        arb_ibuf_grnt,
    output logic        arb_ifetch_rsp_vld,
    output logic [31:0] arb_ifetch_rsp_data,
    output logic        arb_ifetch_rsp_err,
    output logic [1:0]  arb_ifetch_rsp_src,
    output logic        arb_ctrl_idle
);
    localparam int unsigned AW = 32;
    localparam int unsigned PW = (OUTSTD_MAX > 1) ? $clog2(OUTSTD_MAX) : 1;
    localparam int unsigned CW = $clog2(OUTSTD_MAX + 1);
    localparam logic [1:0]  SRC_VEC   = 2'd0;
    localparam logic [1:0]  SRC_PCGEN = 2'd1;
    localparam logic [1:0]  SRC_IBUF  = 2'd2;

    logic          lock_vld;
    logic [1:0]    lock_src;
    logic [AW-1:0] lock_addr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    fifo_src  [OUTSTD_MAX];
    logic          fifo_kill [OUTSTD_MAX];

    logic          ibuf_ok;
    logic          full;
    logic          win_vld;
    logic [1:0]    win_src;
    logic [AW-1:0] win_addr;
    logic          bus_vld;
    logic [1:0]    bus_src;
    logic [AW-1:0] bus_addr;
    logic          push;
    logic          pop;
    logic          rsp_fwd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTD_MAX - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef PA_IFU_ARB_SEQ_THROTTLE_EN
    assign ibuf_ok = ibuf_arb_req_vld & (cnt == '0);
`else
    assign ibuf_ok = ibuf_arb_req_vld;
`endif

    assign full = (cnt == CW'(OUTSTD_MAX));

    // Winner selection; a held lock overrides any new requester
    always_comb begin
        win_vld  = 1'b0;
        win_src  = SRC_VEC;
        win_addr = '0;
        if (vec_arb_req_vld) begin
            win_vld  = 1'b1;
            win_src  = SRC_VEC;
            win_addr = vec_arb_req_addr;
        end else if (pcgen_arb_req_vld) begin
            win_vld  = 1'b1;
            win_src  = SRC_PCGEN;
            win_addr = pcgen_arb_req_addr;
        end else if (ibuf_ok) begin
            win_vld  = 1'b1;
            win_src  = SRC_IBUF;
            win_addr = ibuf_arb_req_addr;
        end
        if (lock_vld) begin
            bus_vld  = 1'b1;
            bus_src  = lock_src;
            bus_addr = lock_addr;
        end else begin
            bus_vld  = win_vld & ~full & ~ctrl_arb_abort;
            bus_src  = win_src;
            bus_addr = win_addr;
        end
    end

    assign push = bus_arb_req_grnt & bus_vld;
    assign pop  = bus_arb_rsp_vld & (cnt != '0);
    assign rsp_fwd = pop & ~fifo_kill[rd_ptr] & ~ctrl_arb_abort;

    always_comb begin
        cnt_nxt = cnt;
        if (push & ~pop) begin
            cnt_nxt = cnt + CW'(1);
        end else if (pop & ~push) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    assign arb_bus_req_vld     = bus_vld;
    assign arb_bus_req_addr    = bus_vld ? bus_addr : '0;
    assign arb_vec_grnt        = push & (bus_src == SRC_VEC);
    assign arb_pcgen_grnt      = push & (bus_src == SRC_PCGEN);
    assign arb_ibuf_grnt       = push & (bus_src == SRC_IBUF);
    assign arb_ifetch_rsp_vld  = rsp_fwd;
    assign arb_ifetch_rsp_data = rsp_fwd ? bus_arb_rsp_data : '0;
    assign arb_ifetch_rsp_err  = rsp_fwd & bus_arb_rsp_err;
    assign arb_ifetch_rsp_src  = rsp_fwd ? fifo_src[rd_ptr] : SRC_VEC;
    assign arb_ctrl_idle       = (cnt == '0) & ~lock_vld;

    // Lock, occupancy and in-flight FIFO; abort marks every entry stale
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            lock_vld  <= 1'b0;
            lock_src  <= SRC_VEC;
            lock_addr <= '0;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < int'(OUTSTD_MAX); i++) begin
                fifo_src[i]  <= SRC_VEC;
                fifo_kill[i] <= 1'b0;
            end
        end else begin
            if (ctrl_arb_abort | push) begin
                lock_vld <= 1'b0;
            end else if (bus_vld) begin
                lock_vld  <= 1'b1;
                lock_src  <= bus_src;
                lock_addr <= bus_addr;
            end
            cnt <= cnt_nxt;
            if (ctrl_arb_abort) begin
                for (int i = 0; i < int'(OUTSTD_MAX); i++) begin
                    fifo_kill[i] <= 1'b1;
                end
            end
            if (push) begin
                fifo_src[wr_ptr]  <= bus_src;
                fifo_kill[wr_ptr] <= ctrl_arb_abort;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

endmodule

// File: doc/pa_ifu_fetch_arb.md
# pa_ifu_fetch_arb

Fetch-request arbiter and outstanding-transaction tracker between the IFU requesters and the single instruction-bus request port. It selects among vector-table, change-of-flow (pcgen) and sequential prefetch (I-buf) requests, holds the bus request stable until it is granted, and tracks in-flight fetches. On a front-end abort it kills in-flight responses so stale instructions never reach ifetch. It reports idle to the IFU control logic, which uses it for low-power and debug entry.

## Interface
- OUTSTD_MAX, 2, maximum in-flight bus fetches (1..4)
- forever_cpuclk  in  1  core clock
- cpurst  in  1  reset, synchronous, active-high
- vec_arb_req_vld / vec_arb_req_addr  in  1/32  vector-table fetch request
- pcgen_arb_req_vld / pcgen_arb_req_addr  in  1/32  change-of-flow fetch request
- ibuf_arb_req_vld / ibuf_arb_req_addr  in  1/32  sequential prefetch request, already qualified by the IFU fetch-enable
- ctrl_arb_abort  in  1  front-end flush (the IFU control abort)
- arb_bus_req_vld / arb_bus_req_addr  out  1/32  bus request
- bus_arb_req_grnt  in  1  bus accepts the request this cycle
- bus_arb_rsp_vld / bus_arb_rsp_data / bus_arb_rsp_err  in  1/32/1  in-order bus response
- arb_vec_grnt, arb_pcgen_grnt, arb_ibuf_grnt  out  1 each  requester's request accepted this cycle
- arb_ifetch_rsp_vld / _data / _err / _src  out  1/32/1/2  forwarded response; src 0=vec, 1=pcgen, 2=ibuf
- arb_ctrl_idle  out  1  no in-flight fetch and no pending request

## Operation
- Priority: vec > pcgen > ibuf, fixed.
- Lock register {lock_vld, lock_src, lock_addr}. When arb_bus_req_vld=1 and grant=0, the lock captures the winner. While lock_vld=1, the bus is driven from the lock and new requesters are ignored. The lock clears on grant.
- When unlocked, the bus request is the combinational winner. It is masked when cnt==OUTSTD_MAX or when ctrl_arb_abort=1.
- Requester grant is bus_arb_req_grnt & arb_bus_req_vld & (src match). Requesters hold req_vld/addr until granted or until they see an abort.
- Abort with lock_vld=1: the lock clears in the same cycle and the request is dropped (bus_arb_req_vld=0 the next cycle). The bus tolerates withdrawal of an ungranted request.
- In-flight FIFO of depth OUTSTD_MAX, entry {src, kill}. Push on grant, pop on bus_arb_rsp_vld. cnt is the occupancy: cnt_next = cnt + push - pop.
- Abort sets kill on every valid entry, including one pushed in the same cycle.
- Popped entry with kill=1: the response is dropped (arb_ifetch_rsp_vld=0). Otherwise data/err/src pass through combinationally in the pop cycle.
- Response in the same cycle as abort: dropped.
- Response with cnt==0: ignored, no state change.
- arb_ctrl_idle = (cnt==0) & ~lock_vld.

## Timing
- Reset values: all outputs 0 except arb_ctrl_idle=1. cnt=0, FIFO empty, lock_vld=0.
- Reset mid-operation returns to the reset state on the next edge. Later responses are ignored (cnt==0 rule).
- Request to bus: 0 cycles (combinational) when unlocked. Grant is visible to the requester in the same cycle.
- Response to ifetch: 0 cycles.
- Back-to-back grants every cycle up to OUTSTD_MAX. Push and pop together at cnt==OUTSTD_MAX is legal; the new issue still waits one cycle because the mask uses the registered cnt.
- FIFO pointers wrap modulo OUTSTD_MAX.

## Configuration
- PA_IFU_ARB_SEQ_THROTTLE_EN defined: ibuf requests are masked while cnt>=1, so at most one in-flight fetch when the sequential source wins. vec and pcgen still use OUTSTD_MAX.
- Not defined: ibuf uses the full OUTSTD_MAX like the other sources.

## Test plan
- pcgen and ibuf request together, grant held low 3 cycles: bus addr stays at the pcgen addr for 4 cycles, arb_pcgen_grnt=1 only on cycle 4, arb_ibuf_grnt=0 throughout.
- Locked pcgen request, vec asserts in cycle 2: the bus keeps the pcgen addr until grant; vec is issued the following cycle.
- OUTSTD_MAX=2, two ibuf grants, no response: arb_bus_req_vld=0 with ibuf still requesting. After one response, a new grant occurs the next cycle.
- Two in-flight fetches, abort, then 2 responses 0xDEAD0001/0xDEAD0002: arb_ifetch_rsp_vld stays 0, cnt returns to 0, arb_ctrl_idle=1.
- Abort while locked and ungranted: arb_bus_req_vld=0 the next cycle and cnt is unchanged. A grant in the abort cycle pushes a killed entry, and its response is dropped.
- With PA_IFU_ARB_SEQ_THROTTLE_EN, ibuf requesting continuously: at most one in-flight fetch. Without the macro, two in-flight fetches.
